// File: rtl/mips_rf_pkg.sv
// Shared widths and types for the MIPS register file and its scoreboard.
package mips_rf_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with set-wins priority, plus RAW hazard detection for rs1/rs2.
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rw,
  input  logic              issue_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  output logic              hazard,
  output logic [DEPTH-1:0]  busy
);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_busy_next;
  logic             w_fwd1;
  logic             w_fwd2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      // A new producer supersedes the retiring one, so set overrides clear.
      assign w_set[gi] = issue_en && (rw == ADDR_W'(gi)) && !((ZERO_REG != 0) && (gi == 0));
      assign w_clr[gi] = wr_en && (wr_addr == ADDR_W'(gi));
      assign w_busy_next[gi] = w_set[gi] | (r_busy[gi] & ~w_clr[gi]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_busy[gi] <= 1'b0;
        end else begin
          r_busy[gi] <= w_busy_next[gi];
        end
      end
    end
  endgenerate

  assign w_fwd1 = (BYPASS != 0) && wr_en && (wr_addr == rs1);
  assign w_fwd2 = (BYPASS != 0) && wr_en && (wr_addr == rs2);

  assign hazard = (r_busy[rs1] & ~w_fwd1) | (r_busy[rs2] & ~w_fwd2);
  assign busy   = r_busy;

endmodule

// File: rtl/reg_file_sb.sv
// Clocked 3-read/1-write register file with optional bypass and zero register, plus RAW scoreboard.
module reg_file_sb
  import mips_rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] rw,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  output logic              hazard,
  output logic [DEPTH-1:0]  busy
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_we;
  logic [ADDR_W-1:0] w_raddr [3];
  logic [DATA_W-1:0] w_rdata [3];
  logic [2:0]        w_zero;
  logic [2:0]        w_fwd;

  assign w_we = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= '0;
        end else if (w_we && (wr_addr == ADDR_W'(gi))) begin
          r_mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign w_raddr[0] = rs1;
  assign w_raddr[1] = rs2;
  assign w_raddr[2] = rw;

  // Forwarding is suppressed while reset is held so all read ports show 0.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rport
      assign w_zero[gi]  = (ZERO_REG != 0) && (w_raddr[gi] == '0);
      assign w_fwd[gi]   = (BYPASS != 0) && rst_n && wr_en && (wr_addr == w_raddr[gi]);
      assign w_rdata[gi] = w_zero[gi] ? '0 :
                           w_fwd[gi]  ? wr_data : r_mem[w_raddr[gi]];
    end
  endgenerate

  assign rd1 = w_rdata[0];
  assign rd2 = w_rdata[1];
  assign rd3 = w_rdata[2];

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1      (rs1),
    .rs2      (rs2),
    .rw       (rw),
    .issue_en (issue_en),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .hazard   (hazard),
    .busy     (busy)
  );

endmodule
